zip_wb_arbiter: RTL and testbench

- Two-master to one-slave pipelined Wishbone (B4) arbiter for the ZipCPU core bus.
- Master A is the instruction prefetch; master B is the data memory unit.
- Grant is held for an entire CYC so that prefetch aborts and multi-beat data cycles are never split.
- Includes an outstanding-request counter and a bus timeout, so a dead slave returns an error instead of hanging the CPU.

---
 rtl/zip_wb_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_zip_wb_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/zip_wb_arbiter.sv
// zip_wb_arbiter
//   Two-master to one-slave pipelined Wishbone (B4) arbiter for the ZipCPU
//   core bus.
//   - Master A is the instruction prefetch. Master B is the data unit.
//   - A grant is held for a whole CYC, so aborts and multi-beat cycles
//     are never split between masters.
//   - An outstanding-request counter caps how many requests are in flight.
//   - A bus timeout turns a dead slave into an error for the owner.
// Ports
//   i_clk, i_reset_n       clock (rising edge), async active-low reset
//   i_a_* / o_a_*          master A request and returns
//   i_b_* / o_b_*          master B request and returns
//   o_wb_* / i_wb_*        slave-side request and returns
//   o_rdata                slave read data, passed to both masters
//   o_timeout              one-cycle pulse when a timeout error is issued
module zip_wb_arbiter #(
  parameter int unsigned AW             = 30,
  parameter int unsigned DW             = 32,
  parameter bit          OPT_ROUNDROBIN = 1'b1,
  parameter int unsigned LGPIPE         = 4,
  parameter int unsigned TIMEOUT        = 1023,
  parameter int unsigned LGTIMEOUT      = 10
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_stall,
  output logic            o_a_ack,
  output logic            o_a_err,
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_stall,
  output logic            o_b_ack,
  output logic            o_b_err,
  output logic [DW-1:0]   o_rdata,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data,
  output logic            o_timeout
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_t;

  localparam logic [LGTIMEOUT-1:0] TLAST = LGTIMEOUT'(TIMEOUT - 1);

  owner_t                r_owner, w_owner_nxt;
  logic                  r_last;      // 0 = A owned last, 1 = B owned last
  logic                  w_last_nxt;
  logic [LGPIPE-1:0]     r_npending;
  logic [LGTIMEOUT-1:0]  r_timer;
  logic                  r_killed;

  logic w_own_cyc, w_own_stb, w_full, w_inc, w_dec;
  logic w_timeout, w_ack, w_err;

  // Owner's request lines; NONE reads as idle.
  always_comb begin
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    case (r_owner)
      OWN_A:   begin w_own_cyc = i_a_cyc; w_own_stb = i_a_stb; end
      OWN_B:   begin w_own_cyc = i_b_cyc; w_own_stb = i_b_stb; end
      default: begin w_own_cyc = 1'b0;    w_own_stb = 1'b0;    end
    endcase
  end

  assign w_full    = &r_npending;
  assign o_wb_cyc  = w_own_cyc & !r_killed;
  // With the counter full the owner sees a stall, so its strobe must not
  // reach the slave either, otherwise the slave would take a request the
  // master believes was refused.
  assign o_wb_stb  = w_own_stb & o_wb_cyc & !w_full;

  assign o_wb_we   = (r_owner == OWN_B) ? i_b_we   : i_a_we;
  assign o_wb_addr = (r_owner == OWN_B) ? i_b_addr : i_a_addr;
  assign o_wb_data = (r_owner == OWN_B) ? i_b_data : i_a_data;
  assign o_wb_sel  = (r_owner == OWN_B) ? i_b_sel  : i_a_sel;
  assign o_rdata   = i_wb_data;

  assign w_inc = o_wb_stb & !i_wb_stall;
  assign w_dec = i_wb_ack & o_wb_cyc;

  // An ack or err landing on the last timer cycle wins over the timeout.
  assign w_timeout = (TIMEOUT != 0) && o_wb_cyc && (r_npending != '0)
                     && !i_wb_ack && !i_wb_err && (r_timer == TLAST);

  assign w_err = (i_wb_err & o_wb_cyc) | w_timeout;
  assign w_ack = i_wb_ack & o_wb_cyc & !i_wb_err;

  assign o_a_ack   = (r_owner == OWN_A) & w_ack;
  assign o_b_ack   = (r_owner == OWN_B) & w_ack;
  assign o_a_err   = (r_owner == OWN_A) & w_err;
  assign o_b_err   = (r_owner == OWN_B) & w_err;
  assign o_a_stall = (r_owner == OWN_A) ? (i_wb_stall | r_killed | w_full) : 1'b1;
  assign o_b_stall = (r_owner == OWN_B) ? (i_wb_stall | r_killed | w_full) : 1'b1;
  assign o_timeout = w_timeout;

  // Ownership next state.
  always_comb begin
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    if (!w_own_cyc) begin
      if (i_a_cyc && i_b_cyc) begin
        if (OPT_ROUNDROBIN)
          w_owner_nxt = r_last ? OWN_A : OWN_B;
        else
          w_owner_nxt = OWN_B;
      end else if (i_a_cyc) begin
        w_owner_nxt = OWN_A;
      end else if (i_b_cyc) begin
        w_owner_nxt = OWN_B;
      end else begin
        w_owner_nxt = OWN_NONE;
      end
    end
    if (w_owner_nxt == OWN_A)
      w_last_nxt = 1'b0;
    else if (w_owner_nxt == OWN_B)
      w_last_nxt = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_owner <= OWN_NONE;
      r_last  <= 1'b0;
    end else begin
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      r_npending <= '0;
    else if (!o_wb_cyc || i_wb_err || w_timeout)
      r_npending <= '0;
    else if (w_inc && !w_dec)
      r_npending <= r_npending + LGPIPE'(1);
    else if (!w_inc && w_dec)
      r_npending <= r_npending - LGPIPE'(1);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      r_timer <= '0;
    else if ((r_npending == '0) || i_wb_ack || i_wb_err || w_timeout)
      r_timer <= '0;
    else if (o_wb_cyc)
      r_timer <= r_timer + LGTIMEOUT'(1);
  end

  // killed keeps the slave cycle dropped until the owner ends its CYC.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      r_killed <= 1'b0;
    else if (w_timeout)
      r_killed <= 1'b1;
    else if (!w_own_cyc)
      r_killed <= 1'b0;
  end

endmodule

// File: tb/tb_zip_wb_arbiter.sv
module tb_zip_wb_arbiter;
  localparam int AW = 30;
  localparam int DW = 32;

  logic            i_clk = 1'b0;
  logic            i_reset_n;
  logic            i_a_cyc, i_a_stb, i_a_we;
  logic [AW-1:0]   i_a_addr;
  logic [DW-1:0]   i_a_data;
  logic [DW/8-1:0] i_a_sel;
  logic            o_a_stall, o_a_ack, o_a_err;
  logic            i_b_cyc, i_b_stb, i_b_we;
  logic [AW-1:0]   i_b_addr;
  logic [DW-1:0]   i_b_data;
  logic [DW/8-1:0] i_b_sel;
  logic            o_b_stall, o_b_ack, o_b_err;
  logic [DW-1:0]   o_rdata;
  logic            o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0]   o_wb_addr;
  logic [DW-1:0]   o_wb_data;
  logic [DW/8-1:0] o_wb_sel;
  logic            i_wb_stall, i_wb_ack, i_wb_err;
  logic [DW-1:0]   i_wb_data;
  logic            o_timeout;

  int checks = 0;
  int errors = 0;

  zip_wb_arbiter #(
    .AW(AW), .DW(DW), .OPT_ROUNDROBIN(1'b1), .LGPIPE(4),
    .TIMEOUT(8), .LGTIMEOUT(4)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we),
    .i_a_addr(i_a_addr), .i_a_data(i_a_data), .i_a_sel(i_a_sel),
    .o_a_stall(o_a_stall), .o_a_ack(o_a_ack), .o_a_err(o_a_err),
    .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we),
    .i_b_addr(i_b_addr), .i_b_data(i_b_data), .i_b_sel(i_b_sel),
    .o_b_stall(o_b_stall), .o_b_ack(o_b_ack), .o_b_err(o_b_err),
    .o_rdata(o_rdata),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic nxt();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_a_cyc = 0; i_a_stb = 0; i_a_we = 0; i_a_addr = '0; i_a_data = 32'hA0A0_0001; i_a_sel = 4'hF;
    i_b_cyc = 0; i_b_stb = 0; i_b_we = 1; i_b_addr = '0; i_b_data = 32'hB0B0_0002; i_b_sel = 4'h3;
    i_wb_stall = 0; i_wb_ack = 0; i_wb_err = 0; i_wb_data = 32'h1234_5678;
    #3;
    chk("rst_wb_cyc",  32'(o_wb_cyc), 0);
    chk("rst_wb_stb",  32'(o_wb_stb), 0);
    chk("rst_a_stall", 32'(o_a_stall), 1);
    chk("rst_b_stall", 32'(o_b_stall), 1);
    chk("rst_acks",    32'({o_a_ack, o_b_ack, o_a_err, o_b_err}), 0);
    chk("rst_pend",    32'(dut.r_npending), 0);
    chk("rdata_pass",  o_rdata, 32'h1234_5678);
    nxt(); nxt();
    i_reset_n = 1'b1;

    // Single master A read, slave acks two cycles after the strobe.
    nxt();
    i_a_cyc = 1; i_a_stb = 1; i_a_addr = 30'h100;
    #2 chk("t1_a_stall_pre", 32'(o_a_stall), 1);
    nxt();
    #1;
    chk("t1_addr",   32'(o_wb_addr), 32'h100);
    chk("t1_wb_stb", 32'(o_wb_stb), 1);
    chk("t1_a_stall",32'(o_a_stall), 0);
    chk("t1_sel",    32'(o_wb_sel), 32'hF);
    nxt();
    i_a_stb = 0;
    #2 chk("t1_pend1", 32'(dut.r_npending), 1);
    chk("t1_noack",  32'(o_a_ack), 0);
    nxt();
    i_wb_ack = 1;
    #2 chk("t1_a_ack", 32'(o_a_ack), 1);
    chk("t1_b_ack",  32'(o_b_ack), 0);
    nxt();
    i_wb_ack = 0;
    #2 chk("t1_pend0", 32'(dut.r_npending), 0);
    chk("t1_ack_once", 32'(o_a_ack), 0);
    i_a_cyc = 0;
    nxt();

    // Contention: last owner was A, so B wins; A follows with no idle cycle.
    i_a_cyc = 1; i_b_cyc = 1; i_a_addr = 30'h0AA; i_b_addr = 30'h200;
    nxt();
    #1;
    chk("t2_b_grant",  32'(o_b_stall), 0);
    chk("t2_a_wait",   32'(o_a_stall), 1);
    chk("t2_b_addr",   32'(o_wb_addr), 32'h200);
    chk("t2_b_we",     32'(o_wb_we), 1);
    chk("t2_b_data",   o_wb_data, 32'hB0B0_0002);
    i_b_cyc = 0;
    #1 chk("t2_b_drop", 32'(o_wb_cyc), 0);
    nxt();
    #1;
    chk("t2_a_grant", 32'(o_a_stall), 0);
    chk("t2_a_cyc",   32'(o_wb_cyc), 1);
    chk("t2_a_addr",  32'(o_wb_addr), 32'h0AA);
    chk("t2_last_a",  32'(dut.r_last), 0);
    i_a_cyc = 0;
    nxt();

    // Abort after three strobes; late acks must be dropped.
    i_a_cyc = 1; i_a_stb = 1; i_a_addr = 30'h10;
    nxt();
    nxt();
    i_a_addr = 30'h11;
    nxt();
    i_a_addr = 30'h12;
    #2 chk("t3_pend2", 32'(dut.r_npending), 2);
    nxt();
    #1 chk("t3_pend3", 32'(dut.r_npending), 3);
    i_a_cyc = 0; i_a_stb = 0; i_wb_ack = 1;
    #1;
    chk("t3_cyc_drop", 32'(o_wb_cyc), 0);
    chk("t3_no_ack_a", 32'(o_a_ack), 0);
    nxt();
    #1;
    chk("t3_pend0",  32'(dut.r_npending), 0);
    chk("t3_late_ack", 32'({o_a_ack, o_b_ack}), 0);
    i_wb_ack = 0;
    nxt();

    // Timeout with TIMEOUT=8: B strobes once, slave never answers.
    i_b_cyc = 1; i_b_stb = 1; i_b_addr = 30'h300;
    nxt();
    #1 chk("t4_accept", 32'(o_wb_stb), 1);
    nxt();
    i_b_stb = 0;
    for (int i = 0; i < 7; i++) begin
      #2 chk("t4_no_err", 32'({o_b_err, o_timeout}), 0);
      nxt();
    end
    #2;
    chk("t4_b_err",   32'(o_b_err), 1);
    chk("t4_timeout", 32'(o_timeout), 1);
    chk("t4_a_err",   32'(o_a_err), 0);
    nxt();
    #2;
    chk("t4_err_pulse", 32'({o_b_err, o_timeout}), 0);
    chk("t4_killed_cyc", 32'(o_wb_cyc), 0);
    chk("t4_killed_stall", 32'(o_b_stall), 1);
    nxt();
    #2 chk("t4_still_dead", 32'(o_wb_cyc), 0);
    i_b_cyc = 0;
    nxt();
    #2 chk("t4_killed_clr", 32'(dut.r_killed), 0);

    // Slave err together with ack on A's first beat.
    i_a_cyc = 1; i_a_stb = 1; i_a_addr = 30'h40;
    nxt();
    nxt();
    i_a_stb = 0; i_wb_err = 1; i_wb_ack = 1;
    #2;
    chk("t5_a_err", 32'(o_a_err), 1);
    chk("t5_a_ack", 32'(o_a_ack), 0);
    nxt();
    i_wb_err = 0; i_wb_ack = 0;
    #2 chk("t5_pend0", 32'(dut.r_npending), 0);
    i_a_cyc = 0;
    nxt();

    // Asynchronous reset while B owns the bus with two requests pending.
    i_b_cyc = 1; i_b_stb = 1; i_b_addr = 30'h50;
    nxt();
    nxt();
    nxt();
    i_b_stb = 0;
    #1 chk("t6_pend2", 32'(dut.r_npending), 2);
    i_reset_n = 0;
    #1;
    chk("t6_rst_cyc",   32'(o_wb_cyc), 0);
    chk("t6_rst_owner", 32'(dut.r_owner), 0);
    chk("t6_rst_stall", 32'({o_a_stall, o_b_stall}), 3);
    chk("t6_rst_pend",  32'(dut.r_npending), 0);
    nxt();
    i_reset_n = 1; i_b_cyc = 0;
    nxt();
    i_a_cyc = 1; i_a_stb = 1; i_a_addr = 30'h77;
    nxt();
    #1;
    chk("t6_a_grant", 32'(o_a_stall), 0);
    chk("t6_a_cyc",   32'(o_wb_cyc), 1);
    chk("t6_a_addr",  32'(o_wb_addr), 32'h77);
    i_a_cyc = 0; i_a_stb = 0;
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
